// File: rtl/ascii_case_stream.sv
// ascii_case_stream: LANES-wide ASCII case converter feeding a 2-entry registered skid buffer,
// with a saturating count of modified bytes. Define ASCII_CASE_TITLE_EN to turn mode 11 into title case.
module ascii_case_stream #(
  parameter int LANES = 1,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*LANES-1:0]   in_data,
  input  logic                 in_last,
  input  logic [1:0]           in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LANES-1:0]   out_data,
  output logic                 out_last,
  input  logic                 clr_count,
  output logic [CNT_W-1:0]     mod_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  localparam logic [1:0] MODE_PASS  = 2'd0;
  localparam logic [1:0] MODE_UPPER = 2'd1;
  localparam logic [1:0] MODE_LOWER = 2'd2;
  localparam logic [1:0] MODE_ALT   = 2'd3;

  occ_t               occ;
  occ_t               occ_next;
  logic               accept;
  logic               pop;
  logic [8*LANES-1:0] conv_data;
  logic [8*LANES-1:0] data_a;
  logic [8*LANES-1:0] data_b;
  logic               last_a;
  logic               last_b;
  logic [CNT_W:0]     n_mod;
  logic [CNT_W:0]     cnt_sum;
`ifdef ASCII_CASE_TITLE_EN
  logic               in_word;
  logic               word_next;
`endif

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  // Per-lane conversion; the word flag ripples from lane 0 upward so title case spans lanes.
  always_comb begin
    logic [7:0] ch;
    logic [7:0] res;
    logic       is_up;
    logic       is_lo;
    conv_data = '0;
    n_mod     = '0;
    ch        = '0;
    res       = '0;
    is_up     = 1'b0;
    is_lo     = 1'b0;
`ifdef ASCII_CASE_TITLE_EN
    word_next = in_word;
`endif
    for (int i = 0; i < LANES; i++) begin
      ch    = in_data[8*i +: 8];
      is_up = (ch >= 8'h41) && (ch <= 8'h5A);
      is_lo = (ch >= 8'h61) && (ch <= 8'h7A);
      res   = ch;
      case (in_mode)
        MODE_PASS:  res = ch;
        MODE_UPPER: if (is_lo) res = ch & 8'hDF;
        MODE_LOWER: if (is_up) res = ch | 8'h20;
        MODE_ALT: begin
`ifdef ASCII_CASE_TITLE_EN
          if (is_up || is_lo) begin
            res       = word_next ? (ch | 8'h20) : (ch & 8'hDF);
            word_next = 1'b1;
          end else begin
            word_next = 1'b0;
          end
`else
          if (is_up || is_lo) res = ch ^ 8'h20;
`endif
        end
        default: res = ch;
      endcase
      conv_data[8*i +: 8] = res;
      if (res != ch) n_mod = n_mod + {{CNT_W{1'b0}}, 1'b1};
    end
  end

`ifdef ASCII_CASE_TITLE_EN
  // End of string resets the word context whatever the beat's mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_word <= 1'b0;
    end else if (accept) begin
      in_word <= in_last ? 1'b0 : word_next;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) occ <= EMPTY;
    else        occ <= occ_next;
  end

  always_comb begin
    occ_next = occ;
    case (occ)
      EMPTY: if (accept) occ_next = ONE;
      ONE: begin
        if (accept && !pop)      occ_next = TWO;
        else if (!accept && pop) occ_next = EMPTY;
      end
      TWO:     if (pop) occ_next = ONE;
      default: occ_next = EMPTY;
    endcase
  end

  // Handshake outputs decode the occupancy register only, so out_ready never reaches in_ready.
  always_comb begin
    in_ready  = (occ != TWO);
    out_valid = (occ != EMPTY);
  end

  // Entry A is the head; it keeps its last value when the buffer drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_a <= '0;
      data_b <= '0;
      last_a <= 1'b0;
      last_b <= 1'b0;
    end else begin
      case (occ)
        EMPTY: begin
          if (accept) begin
            data_a <= conv_data;
            last_a <= in_last;
          end
        end
        ONE: begin
          if (accept && pop) begin
            data_a <= conv_data;
            last_a <= in_last;
          end else if (accept) begin
            data_b <= conv_data;
            last_b <= in_last;
          end
        end
        TWO: begin
          if (pop) begin
            data_a <= data_b;
            last_a <= last_b;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data = data_a;
  assign out_last = last_a;

  assign cnt_sum = {1'b0, mod_count} + (accept ? n_mod : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              mod_count <= '0;
    else if (clr_count)      mod_count <= '0;
    else if (cnt_sum[CNT_W]) mod_count <= '1;
    else                     mod_count <= cnt_sum[CNT_W-1:0];
  end

endmodule

// File: tb/tb_ascii_case_stream.sv
// tb_ascii_case_stream: table vectors, directed corner sequences and a random run against a
// queue-based reference model; a 4-lane/16-bit instance plus a 1-lane/4-bit instance.
module tb_ascii_case_stream;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic        iv = 1'b0, ir, il = 1'b0, ov, ordy = 1'b1, ol, clr = 1'b0;
  logic [31:0] id = '0, od;
  logic [1:0]  im = '0;
  logic [15:0] mc;

  logic        iv1 = 1'b0, ir1, il1 = 1'b0, ov1, ordy1 = 1'b1, ol1, clr1 = 1'b0;
  logic [7:0]  id1 = '0, od1;
  logic [1:0]  im1 = '0;
  logic [3:0]  mc1;

  int checks = 0;
  int errors = 0;
  int pops   = 0;

  always #5 clk = ~clk;

  ascii_case_stream #(.LANES(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv), .in_ready(ir), .in_data(id), .in_last(il), .in_mode(im),
    .out_valid(ov), .out_ready(ordy), .out_data(od), .out_last(ol),
    .clr_count(clr), .mod_count(mc)
  );

  ascii_case_stream #(.LANES(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv1), .in_ready(ir1), .in_data(id1), .in_last(il1), .in_mode(im1),
    .out_valid(ov1), .out_ready(ordy1), .out_data(od1), .out_last(ol1),
    .clr_count(clr1), .mod_count(mc1)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit isUp(input logic [7:0] c);
    return (c >= 8'h41) && (c <= 8'h5A);
  endfunction

  function automatic bit isLo(input logic [7:0] c);
    return (c >= 8'h61) && (c <= 8'h7A);
  endfunction

  // Reference character rule; makeUpper selects the title-case direction.
  function automatic logic [7:0] refChar(input logic [7:0] c, input logic [1:0] m, input bit makeUpper);
    case (m)
      2'd1: return isLo(c) ? c - 8'h20 : c;
      2'd2: return isUp(c) ? c + 8'h20 : c;
      2'd3: begin
`ifdef ASCII_CASE_TITLE_EN
        if (makeUpper) return isLo(c) ? c - 8'h20 : c;
        else           return isUp(c) ? c + 8'h20 : c;
`else
        if (makeUpper || !makeUpper) return isUp(c) ? c + 8'h20 : (isLo(c) ? c - 8'h20 : c);
        else return c;
`endif
      end
      default: return c;
    endcase
  endfunction

  function automatic logic [7:0] randByte();
    int r = $urandom_range(0, 3);
    case (r)
      0:       return 8'(32'h41 + $urandom_range(0, 25));
      1:       return 8'(32'h61 + $urandom_range(0, 25));
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  // Scoreboard: queue of expected beats mirrors buffer contents; decisions use the model's view.
  typedef struct { logic [31:0] d; logic l; } beat_t;
  beat_t       q[$];
  logic [31:0] lastOut = '0;
  int          expCnt  = 0;
  bit          word    = 1'b0;

  always @(negedge clk) begin : sb
    bit          acc;
    int          n;
    logic [31:0] d;
    logic [7:0]  c;
    acc = 1'b0;
    n   = 0;
    d   = '0;
    c   = '0;
    if (!rst_n) begin
      q.delete();
      expCnt  = 0;
      word    = 1'b0;
      lastOut = '0;
    end else begin
      checkOutput("sb_in_ready", 32'(ir), 32'(q.size() < 2));
      checkOutput("sb_out_valid", 32'(ov), 32'(q.size() != 0));
      if (q.size() != 0) begin
        checkOutput("sb_out_data", od, q[0].d);
        checkOutput("sb_out_last", 32'(ol), 32'(q[0].l));
      end else begin
        checkOutput("sb_idle_hold", od, lastOut);
      end
      checkOutput("sb_mod_count", 32'(mc), expCnt);
      acc = iv && (q.size() < 2);
      if (q.size() != 0 && ordy) begin
        lastOut = q[0].d;
        void'(q.pop_front());
        pops++;
      end
      if (acc) begin
        for (int i = 0; i < 4; i++) begin
          c = id[8*i +: 8];
          d[8*i +: 8] = refChar(c, im, !word);
`ifdef ASCII_CASE_TITLE_EN
          if (im == 2'd3) word = isUp(c) || isLo(c);
`endif
          if (d[8*i +: 8] != c) n++;
        end
        if (il) word = 1'b0;
        q.push_back('{d, il});
      end
      if (clr)      expCnt = 0;
      else if (acc) expCnt = (expCnt + n > 65535) ? 65535 : expCnt + n;
    end
  end

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] data;
    logic        last;
    logic [31:0] expData;
    int          expDelta;
  } vec_t;
  vec_t vecs[$];

  task automatic applyStimulus(input vec_t v);
    @(posedge clk); #1;
    iv = 1'b1; id = v.data; im = v.mode; il = v.last;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (ir) break;
    end
    checkOutput("vec_accept", 32'(ir), 32'd1);
    @(posedge clk); #1;
    iv = 1'b0; il = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [15:0] mcBefore;
    logic [31:0] held;
    int          accepted;
    int          popsBefore;

`ifdef ASCII_CASE_TITLE_EN
    vecs.push_back('{2'd3, 32'h4C4C4568, 1'b0, 32'h6C6C6548, 4});
    vecs.push_back('{2'd3, 32'h4F77206F, 1'b0, 32'h6F57206F, 2});
    vecs.push_back('{2'd3, 32'h20444C52, 1'b1, 32'h20646C72, 3});
    vecs.push_back('{2'd3, 32'h20206261, 1'b1, 32'h20206241, 1});
`else
    vecs.push_back('{2'd3, 32'h7A314261, 1'b0, 32'h5A316241, 3});
    vecs.push_back('{2'd3, 32'h7A615A41, 1'b0, 32'h5A417A61, 4});
`endif
    vecs.push_back('{2'd2, 32'h6F4C6548, 1'b0, 32'h6F6C6568, 2});
    vecs.push_back('{2'd1, 32'h6F4C6548, 1'b0, 32'h4F4C4548, 2});
    vecs.push_back('{2'd0, 32'h805A7E61, 1'b1, 32'h805A7E61, 0});
    vecs.push_back('{2'd1, 32'h7B605B40, 1'b0, 32'h7B605B40, 0});
    vecs.push_back('{2'd2, 32'h7B605B40, 1'b0, 32'h7B605B40, 0});
    vecs.push_back('{2'd1, 32'hFAE1C180, 1'b1, 32'hFAE1C180, 0});

    #12;
    checkOutput("rst_in_ready", 32'(ir), 32'd1);
    checkOutput("rst_out_valid", 32'(ov), 32'd0);
    checkOutput("rst_out_data", od, 32'd0);
    checkOutput("rst_out_last", 32'(ol), 32'd0);
    checkOutput("rst_mod_count", 32'(mc), 32'd0);
    checkOutput("rst1_out_valid", 32'(ov1), 32'd0);
    checkOutput("rst1_out_last", 32'(ol1), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("[TB] table vectors");
    ordy = 1'b1;
    foreach (vecs[k]) begin
      mcBefore = mc;
      applyStimulus(vecs[k]);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_valid", k), 32'(ov), 32'd1);
      checkOutput($sformatf("vec%0d_data", k), od, vecs[k].expData);
      checkOutput($sformatf("vec%0d_last", k), 32'(ol), 32'(vecs[k].last));
      checkOutput($sformatf("vec%0d_delta", k), 32'(mc - mcBefore), vecs[k].expDelta);
    end

    $display("[TB] single-lane upper sweep");
    ordy1 = 1'b1; im1 = 2'd1; clr1 = 1'b0;
    for (int b = 0; b < 256; b++) begin
      @(posedge clk); #1;
      iv1 = 1'b1; id1 = 8'(b);
      @(negedge clk);
      checkOutput("sweep_in_ready", 32'(ir1), 32'd1);
      if (b == 0) begin
        checkOutput("sweep_first_empty", 32'(ov1), 32'd0);
      end else begin
        checkOutput("sweep_valid", 32'(ov1), 32'd1);
        checkOutput($sformatf("sweep_%02h", b - 1), 32'(od1), 32'(refChar(8'(b - 1), 2'd1, 1'b1)));
      end
    end
    @(posedge clk); #1;
    iv1 = 1'b0;
    @(negedge clk);
    checkOutput("sweep_last_byte", 32'(od1), 32'hFF);
    checkOutput("sweep_count_sat", 32'(mc1), 32'd15);
    @(negedge clk);
    checkOutput("sweep_drained", 32'(ov1), 32'd0);
    checkOutput("sweep_empty_hold", 32'(od1), 32'hFF);

    @(posedge clk); #1;
    iv1 = 1'b1; id1 = 8'h61; clr1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0; clr1 = 1'b0;
    @(negedge clk);
    checkOutput("clr_wins_accept", 32'(mc1), 32'd0);
    @(posedge clk); #1;
    iv1 = 1'b1; id1 = 8'h62;
    @(posedge clk); #1;
    iv1 = 1'b0;
    @(negedge clk);
    checkOutput("count_after_clr", 32'(mc1), 32'd1);

    $display("[TB] backpressure");
    ordy = 1'b0; accepted = 0; popsBefore = pops; held = '0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      iv = 1'b1; id = {randByte(), randByte(), randByte(), randByte()};
      im = 2'($urandom_range(0, 3)); il = 1'b0;
      @(negedge clk);
      if (c == 1) held = od;
      if (c >= 2) checkOutput($sformatf("bp_in_ready_c%0d", c + 1), 32'(ir), 32'd0);
      if (c == 4) checkOutput("bp_data_held", od, held);
      if (ir) accepted++;
    end
    @(posedge clk); #1;
    iv = 1'b0; ordy = 1'b1;
    checkOutput("bp_accepted", accepted, 32'd2);
    repeat (4) @(negedge clk);
    checkOutput("bp_drained", 32'(ov), 32'd0);
    checkOutput("bp_pop_count", pops - popsBefore, 32'd2);

    $display("[TB] random traffic");
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      iv   = ($urandom_range(0, 3) != 0);
      id   = {randByte(), randByte(), randByte(), randByte()};
      im   = 2'($urandom_range(0, 3));
      il   = ($urandom_range(0, 4) == 0);
      ordy = ($urandom_range(0, 2) != 0);
      clr  = ($urandom_range(0, 39) == 0);
    end
    @(posedge clk); #1;
    iv = 1'b0; clr = 1'b0; ordy = 1'b1; il = 1'b0;
    repeat (5) @(posedge clk);

    $display("[TB] reset with full buffer");
    #1;
    ordy = 1'b0; im = 2'd1; iv = 1'b1; id = 32'h64636261;
    @(posedge clk); #1;
    id = 32'h68676665;
    @(posedge clk); #1;
    iv = 1'b0;
    @(negedge clk);
    checkOutput("rst_pre_full", 32'(ir), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 32'(ov), 32'd0);
    checkOutput("midrst_in_ready", 32'(ir), 32'd1);
    checkOutput("midrst_mod_count", 32'(mc), 32'd0);
    checkOutput("midrst_out_data", od, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; ordy = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("post_rst_no_emit", 32'(ov), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
